prbs23_chk_ctrl: RTL and testbench
==================================

PRBS23_CHK_CTRL -- requirements
Module: prbs23_chk_ctrl

Interface
REQ-001 Parameter N, 23, PRBS word width; must match the attached generator.
REQ-002 Parameter LOCK_CNT, 8, consecutive matching words required to declare lock (range 1..255).
REQ-003 Parameter LOSS_CNT, 4, consecutive mismatching words that drop lock (range 1..255).
REQ-004 Parameter CNT_W, 32, width of the statistics counters.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a check run.
REQ-008 stop  in  1  one-cycle pulse; aborts the run and returns to IDLE.
REQ-009 rx_valid  in  1  rx_data holds a received word this cycle.
REQ-010 rx_data  in  N  received PRBS word; lsb is the first bit.
REQ-011 prbs_m  in  N  current generator state; the expected next word.
REQ-012 prbs_load  out  1  generator load strobe.
REQ-013 prbs_enable  out  1  generator advance strobe; one N-bit step per cycle.
REQ-014 prbs_seed  out  N  generator seed; combinationally equal to rx_data.
REQ-015 locked  out  1  checker is in lock.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 state  out  3  IDLE=0, SEED=1, ADV=2, LOCK=3, CHECK=4.
REQ-018 word_cnt  out  CNT_W  words compared while in CHECK.
REQ-019 err_cnt  out  CNT_W  mismatching words while in CHECK.
REQ-020 biterr_cnt  out  CNT_W  errored bits while in CHECK; see Configuration.

Function
REQ-021 IDLE: start clears word_cnt, err_cnt and biterr_cnt and moves to SEED; start outside IDLE is ignored.
REQ-022 SEED: a non-zero rx_data with rx_valid asserts prbs_load that cycle and moves to ADV; an all-zero word is discarded and the state stays SEED.
REQ-023 ADV: asserts prbs_enable for exactly one cycle, then moves to LOCK; rx_valid during ADV is dropped and not compared.
REQ-024 LOCK: on rx_valid, compare rx_data with prbs_m and assert prbs_enable in the same cycle.
REQ-025 LOCK match: increment the match counter; on reaching LOCK_CNT, set locked and move to CHECK.
REQ-026 LOCK mismatch: clear the match counter and move to SEED.
REQ-027 CHECK: on rx_valid, assert prbs_enable, increment word_cnt, and on mismatch increment err_cnt.
REQ-028 CHECK: a match clears the loss counter; a mismatch increments it.
REQ-029 CHECK: when the loss counter reaches LOSS_CNT, clear locked and move to SEED; word_cnt and err_cnt keep their values.
REQ-030 All statistics counters saturate at all-ones and never wrap.
REQ-031 stop returns to IDLE from any state on the next edge, clears locked, and leaves the counters holding their values.
REQ-032 stop wins over a simultaneous start, and stop wins over a simultaneous rx_valid: no compare and no counter update.
REQ-033 prbs_load and prbs_enable are never asserted in the same cycle, and neither is asserted in IDLE.
REQ-034 In IDLE, rx_valid has no effect.

Reset
REQ-035 Reset gives state=IDLE; locked, busy, prbs_load and prbs_enable = 0.
REQ-036 Reset clears word_cnt, err_cnt, biterr_cnt, the match counter and the loss counter to 0.
REQ-037 Reset asserted mid-run aborts the run immediately, with no partial counter update.

Configuration
REQ-038 With macro PRBS23_CHK_CTRL_BITERR_EN defined: in CHECK, biterr_cnt adds the popcount of (rx_data XOR prbs_m) on each rx_valid, saturating.
REQ-039 With PRBS23_CHK_CTRL_BITERR_EN undefined: biterr_cnt is tied to 0 and no popcount logic is built.

Verification
REQ-040 Reset, start, one non-zero seed word, then 8 correct words -> locked=1 at the 8th compare and state=CHECK; word_cnt=0, err_cnt=0.
REQ-041 While locked, send 100 words with words 10 and 50 each having 3 bits flipped -> word_cnt=100, err_cnt=2, locked stays 1; biterr_cnt=6 with the macro, 0 without.
REQ-042 While locked, send 4 consecutive corrupted words -> locked=0 on the 4th and state=SEED; a reseed followed by 8 good words relocks.
REQ-043 In SEED, send 23'h000000 -> no prbs_load and state stays SEED; then send 23'h7FFFFF -> prbs_load=1, then prbs_enable for one cycle in ADV.
REQ-044 Pulse start and stop together in CHECK -> state=IDLE next cycle, locked=0, counters held; a later start clears the counters.
REQ-045 Force err_cnt near all-ones, then inject 5 errors -> err_cnt=all-ones with no wrap; reset mid-CHECK -> all outputs return to their reset values.

Source files
------------

// File: rtl/prbs23_chk_ctrl_if.sv
// Receive-word and PRBS-generator handshake between the stream source, generator and checker.
// The source drives rx_*/prbs_m (master); the checker drives the generator strobes (slave).
interface prbs23_chk_ctrl_if #(
    parameter int N = 23
);
    logic         rx_valid;
    logic [N-1:0] rx_data;
    logic [N-1:0] prbs_m;
    logic         prbs_load;
    logic         prbs_enable;
    logic [N-1:0] prbs_seed;

    modport master (
        output rx_valid, rx_data, prbs_m,
        input  prbs_load, prbs_enable, prbs_seed
    );

    modport slave (
        input  rx_valid, rx_data, prbs_m,
        output prbs_load, prbs_enable, prbs_seed
    );
endinterface

// File: rtl/prbs23_chk_ctrl.sv
// PRBS23 checker control: seeds/advances an external generator, locks, counts word and bit errors (bit errors only with PRBS23_CHK_CTRL_BITERR_EN).
// Generator strobes are combinational in the same cycle as rx_valid; no backpressure, every valid word is consumed.
module prbs23_chk_ctrl #(
    parameter int N        = 23,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    prbs23_chk_ctrl_if.slave  bus,
    output logic              locked,
    output logic              busy,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  biterr_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_ADV   = 3'd2,
        ST_LOCK  = 3'd3,
        ST_CHECK = 3'd4
    } st_t;

    localparam logic [7:0] MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0] LOSS_LAST  = 8'(LOSS_CNT - 1);

    st_t        st_q, st_nxt;
    logic [7:0] match_q, loss_q;
    logic       mism, load, adv, chk_vld, clr_stats;

    assign mism            = bus.rx_data != bus.prbs_m;
    assign bus.prbs_seed   = bus.rx_data;
    assign bus.prbs_load   = load;
    assign bus.prbs_enable = adv;
    assign state           = st_q;
    assign busy            = st_q != ST_IDLE;
    assign clr_stats       = (st_q == ST_IDLE) && start && !stop;

    // stop overrides everything, including a same-cycle compare
    always_comb begin
        st_nxt  = st_q;
        load    = 1'b0;
        adv     = 1'b0;
        chk_vld = 1'b0;
        if (stop) begin
            st_nxt = ST_IDLE;
        end else begin
            unique case (st_q)
                ST_IDLE: if (start) st_nxt = ST_SEED;
                ST_SEED: begin
                    if (bus.rx_valid && (bus.rx_data != '0)) begin
                        load   = 1'b1;
                        st_nxt = ST_ADV;
                    end
                end
                ST_ADV: begin
                    adv    = 1'b1;
                    st_nxt = ST_LOCK;
                end
                ST_LOCK: begin
                    if (bus.rx_valid) begin
                        adv = 1'b1;
                        if (mism)                        st_nxt = ST_SEED;
                        else if (match_q == MATCH_LAST)  st_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bus.rx_valid) begin
                        adv     = 1'b1;
                        chk_vld = 1'b1;
                        if (mism && (loss_q == LOSS_LAST)) st_nxt = ST_SEED;
                    end
                end
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            match_q <= '0;
            loss_q  <= '0;
            locked  <= 1'b0;
        end else begin
            st_q   <= st_nxt;
            locked <= st_nxt == ST_CHECK;
            if (st_nxt != ST_LOCK)
                match_q <= '0;
            else if (st_q == ST_LOCK && adv)
                match_q <= match_q + 8'd1;
            if (st_nxt != ST_CHECK)
                loss_q <= '0;
            else if (chk_vld)
                loss_q <= mism ? loss_q + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (clr_stats) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (chk_vld) begin
            if (word_cnt != '1)         word_cnt <= word_cnt + CNT_W'(1);
            if (mism && err_cnt != '1)  err_cnt  <= err_cnt + CNT_W'(1);
        end
    end

`ifdef PRBS23_CHK_CTRL_BITERR_EN
    localparam int PW = $clog2(N + 1);

    logic [N-1:0]    diff;
    logic [PW-1:0]   pop;
    logic [CNT_W:0]  bit_sum;
    logic [CNT_W-1:0] biterr_q;

    assign diff = bus.rx_data ^ bus.prbs_m;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + PW'(diff[i]);
    end

    // one spare carry bit detects overflow for saturation
    assign bit_sum    = {1'b0, biterr_q} + {{(CNT_W + 1 - PW){1'b0}}, pop};
    assign biterr_cnt = biterr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            biterr_q <= '0;
        else if (clr_stats)
            biterr_q <= '0;
        else if (chk_vld)
            biterr_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
`else
    assign biterr_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs23_chk_ctrl.sv
// Directed bench for prbs23_chk_ctrl with a behavioural PRBS23 (x^23+x^18+1) generator.
// Expected values are hand-derived constants; bit-error expectations follow PRBS23_CHK_CTRL_BITERR_EN.
module tb_prbs23_chk_ctrl;
    localparam int N  = 23;
    localparam int CW = 8;
`ifdef PRBS23_CHK_CTRL_BITERR_EN
    localparam bit BIT_EN = 1'b1;
`else
    localparam bit BIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          locked, busy;
    logic [2:0]    state;
    logic [CW-1:0] word_cnt, err_cnt, biterr_cnt;
    logic [N-1:0]  gen;
    logic [N-1:0]  tx;
    logic          ld, en;
    int            checks = 0;
    int            errors = 0;

    prbs23_chk_ctrl_if #(.N(N)) bus();

    prbs23_chk_ctrl #(.N(N), .LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(bus),
        .locked(locked), .busy(busy), .state(state),
        .word_cnt(word_cnt), .err_cnt(err_cnt), .biterr_cnt(biterr_cnt)
    );

    always #5 clk = ~clk;

    // next 23 sequence bits, lsb first: s[k] = s[k-23] ^ s[k-18]
    function automatic logic [N-1:0] nxt(input logic [N-1:0] w);
        logic [N-1:0] n;
        n = '0;
        for (int i = 0; i < N; i++) begin
            if (i < 18) n[i] = w[i] ^ w[i + 5];
            else        n[i] = w[i] ^ n[i - 18];
        end
        return n;
    endfunction

    assign bus.prbs_m = gen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                gen <= '0;
        else if (bus.prbs_load)    gen <= bus.prbs_seed;
        else if (bus.prbs_enable)  gen <= nxt(gen);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [N-1:0] w, output logic o_ld, output logic o_en);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = w;
        #1;
        o_ld = bus.prbs_load;
        o_en = bus.prbs_enable;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic lock_up(input logic [N-1:0] seed);
        send(seed, ld, en);
        chk("relock_load", {31'd0, ld}, 32'd1);
        @(posedge clk); #1;
        chk("relock_adv_done", {29'd0, state}, 32'd3);
        tx = seed;
        for (int i = 0; i < 8; i++) begin
            tx = nxt(tx);
            send(tx, ld, en);
        end
        chk("relock_locked", {31'd0, locked}, 32'd1);
        chk("relock_state", {29'd0, state}, 32'd4);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_load",   {31'd0, bus.prbs_load}, 32'd0);
        chk("rst_enable", {31'd0, bus.prbs_enable}, 32'd0);
        chk("rst_word",   {24'd0, word_cnt}, 32'd0);
        chk("rst_err",    {24'd0, err_cnt}, 32'd0);
        chk("rst_biterr", {24'd0, biterr_cnt}, 32'd0);
        rst_n = 1'b1;

        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_state", {29'd0, state}, 32'd1);
        chk("start_busy",  {31'd0, busy}, 32'd1);

        // zero seed is discarded, all-ones seed is loaded
        send(23'h000000, ld, en);
        chk("zero_seed_load",  {31'd0, ld}, 32'd0);
        chk("zero_seed_state", {29'd0, state}, 32'd1);
        send(23'h7FFFFF, ld, en);
        chk("seed_load",   {31'd0, ld}, 32'd1);
        chk("seed_no_en",  {31'd0, en}, 32'd0);
        chk("seed_state",  {29'd0, state}, 32'd2);
        chk("seed_value",  {9'd0, bus.prbs_seed}, 32'h007FFFFF);
        send(23'h123456, ld, en);
        chk("adv_enable",  {31'd0, en}, 32'd1);
        chk("adv_no_load", {31'd0, ld}, 32'd0);
        chk("adv_state",   {29'd0, state}, 32'd3);

        tx = 23'h7FFFFF;
        for (int i = 1; i <= 8; i++) begin
            tx = nxt(tx);
            send(tx, ld, en);
            if (i == 1) chk("lock_enable", {31'd0, en}, 32'd1);
            if (i == 7) chk("lock_pre7",   {31'd0, locked}, 32'd0);
        end
        chk("lock_locked", {31'd0, locked}, 32'd1);
        chk("lock_state",  {29'd0, state}, 32'd4);
        chk("lock_word",   {24'd0, word_cnt}, 32'd0);
        chk("lock_err",    {24'd0, err_cnt}, 32'd0);

        for (int i = 1; i <= 100; i++) begin
            tx = nxt(tx);
            send((i == 10 || i == 50) ? (tx ^ 23'h400101) : tx, ld, en);
        end
        chk("run_word",   {24'd0, word_cnt}, 32'd100);
        chk("run_err",    {24'd0, err_cnt}, 32'd2);
        chk("run_locked", {31'd0, locked}, 32'd1);
        chk("run_biterr", {24'd0, biterr_cnt}, BIT_EN ? 32'd6 : 32'd0);

        for (int i = 1; i <= 4; i++) begin
            tx = nxt(tx);
            send(tx ^ 23'h000001, ld, en);
            if (i == 3) chk("loss_pre3", {31'd0, locked}, 32'd1);
        end
        chk("loss_locked", {31'd0, locked}, 32'd0);
        chk("loss_state",  {29'd0, state}, 32'd1);
        chk("loss_word",   {24'd0, word_cnt}, 32'd104);
        chk("loss_err",    {24'd0, err_cnt}, 32'd6);
        chk("loss_biterr", {24'd0, biterr_cnt}, BIT_EN ? 32'd10 : 32'd0);

        lock_up(nxt(tx));
        chk("relock_word", {24'd0, word_cnt}, 32'd104);

        // start+stop with a valid word in CHECK: stop wins, nothing counted
        tx = nxt(tx);
        @(negedge clk);
        start = 1'b1; stop = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = tx;
        #1;
        chk("stop_no_en", {31'd0, bus.prbs_enable}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; bus.rx_valid = 1'b0;
        chk("stop_state",  {29'd0, state}, 32'd0);
        chk("stop_locked", {31'd0, locked}, 32'd0);
        chk("stop_busy",   {31'd0, busy}, 32'd0);
        chk("stop_word",   {24'd0, word_cnt}, 32'd104);
        chk("stop_err",    {24'd0, err_cnt}, 32'd6);

        send(tx, ld, en);
        chk("idle_rx_en",    {31'd0, en}, 32'd0);
        chk("idle_rx_ld",    {31'd0, ld}, 32'd0);
        chk("idle_rx_state", {29'd0, state}, 32'd0);

        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_word",   {24'd0, word_cnt}, 32'd0);
        chk("restart_err",    {24'd0, err_cnt}, 32'd0);
        chk("restart_biterr", {24'd0, biterr_cnt}, 32'd0);
        chk("restart_state",  {29'd0, state}, 32'd1);

        lock_up(23'h2ABCDE);
        // alternate bad/good so the loss counter never reaches its limit
        for (int p = 0; p < 250; p++) begin
            tx = nxt(tx); send(tx ^ 23'h000001, ld, en);
            tx = nxt(tx); send(tx, ld, en);
        end
        chk("near_err",    {24'd0, err_cnt}, 32'd250);
        chk("near_word",   {24'd0, word_cnt}, 32'd255);
        chk("near_locked", {31'd0, locked}, 32'd1);
        for (int p = 0; p < 5; p++) begin
            tx = nxt(tx); send(tx ^ 23'h000001, ld, en);
            tx = nxt(tx); send(tx, ld, en);
        end
        chk("sat_err", {24'd0, err_cnt}, 32'd255);
        for (int p = 0; p < 5; p++) begin
            tx = nxt(tx); send(tx ^ 23'h000001, ld, en);
            tx = nxt(tx); send(tx, ld, en);
        end
        chk("sat_err_hold", {24'd0, err_cnt}, 32'd255);
        chk("sat_biterr",   {24'd0, biterr_cnt}, BIT_EN ? 32'd255 : 32'd0);
        chk("sat_locked",   {31'd0, locked}, 32'd1);

        // asynchronous reset mid-cycle while a bad word is presented
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = nxt(tx) ^ 23'h000001;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",  {29'd0, state}, 32'd0);
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_busy",   {31'd0, busy}, 32'd0);
        chk("arst_load",   {31'd0, bus.prbs_load}, 32'd0);
        chk("arst_enable", {31'd0, bus.prbs_enable}, 32'd0);
        chk("arst_word",   {24'd0, word_cnt}, 32'd0);
        chk("arst_err",    {24'd0, err_cnt}, 32'd0);
        chk("arst_biterr", {24'd0, biterr_cnt}, 32'd0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        chk("arst_hold_state", {29'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
